// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, default tap count and FSM state encoding for the FIR tap sequencer
package fir_pkg;

  localparam int DW       = 16;
  localparam int TAPS_DEF = 16;
  localparam int ACC_W    = 39;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// rtl/fir_tap_sequencer_if.sv - sample, coefficient and MAC operand signals of the tap sequencer
// mac_clr exists only when FIR_SEQ_CLR_EN is defined.
interface fir_tap_sequencer_if #(
  parameter int TAPS = fir_pkg::TAPS_DEF,
  parameter int DW   = fir_pkg::DW
);

  localparam int AW = $clog2(TAPS);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_sample;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [DW-1:0] coef_data;
  logic          coef_drop;
  logic [DW-1:0] mac_x;
  logic [DW-1:0] mac_b;
  logic          mac_en;
  logic          frame_done;

`ifdef FIR_SEQ_CLR_EN
  logic          mac_clr;

  modport master (
    output in_valid, in_sample, coef_we, coef_addr, coef_data,
    input  in_ready, coef_drop, mac_x, mac_b, mac_en, frame_done, mac_clr
  );

  modport slave (
    input  in_valid, in_sample, coef_we, coef_addr, coef_data,
    output in_ready, coef_drop, mac_x, mac_b, mac_en, frame_done, mac_clr
  );
`else
  modport master (
    output in_valid, in_sample, coef_we, coef_addr, coef_data,
    input  in_ready, coef_drop, mac_x, mac_b, mac_en, frame_done
  );

  modport slave (
    input  in_valid, in_sample, coef_we, coef_addr, coef_data,
    output in_ready, coef_drop, mac_x, mac_b, mac_en, frame_done
  );
`endif

endinterface

// File: rtl/fir_sample_ring.sv
// rtl/fir_sample_ring.sv - circular sample history with write pointer and a down-counting read pointer
module fir_sample_ring #(
  parameter int TAPS = 16,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_load,
  input  logic          rd_step,
  input  logic          wr_adv,
  output logic [DW-1:0] next_data
);

  localparam int AW = $clog2(TAPS);

  logic [DW-1:0] hist [TAPS];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_prev;

  // The newest term bypasses the ring, so the reader always looks one entry older than rd_ptr.
  assign rd_prev   = rd_ptr - 1'b1;
  assign next_data = hist[rd_prev];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        hist[wr_ptr] <= wr_data;
      end
      if (rd_load) begin
        rd_ptr <= wr_ptr;
      end else if (rd_step) begin
        rd_ptr <= rd_prev;
      end
      if (wr_adv) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - issues TAPS registered sample/coefficient pairs per accepted sample
// Optional mac_clr output enabled by defining FIR_SEQ_CLR_EN.
module fir_tap_sequencer #(
  parameter int TAPS = fir_pkg::TAPS_DEF,
  parameter int DW   = fir_pkg::DW
) (
  input logic                clk,
  input logic                rst,
  fir_tap_sequencer_if.slave bus
);

  import fir_pkg::*;

  localparam int AW = $clog2(TAPS);

  fir_state_t    state;
  fir_state_t    state_nxt;
  logic [AW-1:0] k;
  logic [AW-1:0] k_nxt;
  logic          accept;
  logic          last_tap;
  logic          step;
  logic          done_st;
  logic          coef_wr;
  logic [DW-1:0] coef_b0;
  logic [DW-1:0] ring_next;
  logic [DW-1:0] coef [TAPS];
  logic [DW-1:0] mac_x_q;
  logic [DW-1:0] mac_b_q;
  logic          mac_en_q;
  logic          coef_drop_q;

  assign accept   = bus.in_valid && (state == IDLE);
  assign last_tap = (k == AW'(TAPS - 1));
  assign step     = (state == RUN) && !last_tap;
  assign done_st  = (state == DONE);
  assign k_nxt    = k + 1'b1;
  assign coef_wr  = bus.coef_we && (state == IDLE);
  // A write landing on the acceptance edge must already feed the k=0 term.
  assign coef_b0  = (coef_wr && (bus.coef_addr == '0)) ? bus.coef_data : coef[0];

  fir_sample_ring #(
    .TAPS (TAPS),
    .DW   (DW)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (accept),
    .wr_data   (bus.in_sample),
    .rd_load   (accept),
    .rd_step   (step),
    .wr_adv    (done_st),
    .next_data (ring_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = RUN;
      RUN:     if (last_tap) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.frame_done = done_st;
  assign bus.mac_x      = mac_x_q;
  assign bus.mac_b      = mac_b_q;
  assign bus.mac_en     = mac_en_q;
  assign bus.coef_drop  = coef_drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coef[i] <= '0;
      end
      k           <= '0;
      mac_x_q     <= '0;
      mac_b_q     <= '0;
      mac_en_q    <= 1'b0;
      coef_drop_q <= 1'b0;
    end else begin
      coef_drop_q <= bus.coef_we && (state != IDLE);
      if (coef_wr) begin
        coef[bus.coef_addr] <= bus.coef_data;
      end
      mac_x_q  <= '0;
      mac_b_q  <= '0;
      mac_en_q <= 1'b0;
      if (accept) begin
        k        <= '0;
        mac_x_q  <= bus.in_sample;
        mac_b_q  <= coef_b0;
        mac_en_q <= 1'b1;
      end else if (step) begin
        k        <= k_nxt;
        mac_x_q  <= ring_next;
        mac_b_q  <= coef[k_nxt];
        mac_en_q <= 1'b1;
      end
    end
  end

`ifdef FIR_SEQ_CLR_EN
  logic mac_clr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mac_clr_q <= 1'b0;
    end else begin
      mac_clr_q <= accept;
    end
  end

  assign bus.mac_clr = mac_clr_q;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - scoreboard bench for fir_tap_sequencer (optionally with FIR_SEQ_CLR_EN)
module tb_fir_tap_sequencer;

  localparam int TAPS = 16;
  localparam int DW   = 16;
  localparam int AW   = $clog2(TAPS);

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] b;
    int            k;
  } term_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  term_t         exp_q  [$];
  int            done_q [$];
  logic [DW-1:0] hist_m [TAPS];
  logic [DW-1:0] coef_m [TAPS];
  int            wp_m;

  fir_tap_sequencer_if #(.TAPS(TAPS), .DW(DW)) bus ();

  fir_tap_sequencer #(.TAPS(TAPS), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      hist_m[i] = '0;
      coef_m[i] = '0;
    end
    wp_m = 0;
    exp_q.delete();
    done_q.delete();
  endtask

  // Called at the negedge before the accepting edge.
  task automatic model_accept(input logic [DW-1:0] s);
    term_t t;
    hist_m[wp_m] = s;
    for (int k = 0; k < TAPS; k++) begin
      t.x = hist_m[(wp_m - k + TAPS) % TAPS];
      t.b = coef_m[k];
      t.k = k;
      exp_q.push_back(t);
    end
    done_q.push_back(cyc + TAPS + 1);
    wp_m = (wp_m + 1) % TAPS;
  endtask

  always @(negedge clk) begin
    term_t e;
    if (bus.mac_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_term: got mac_en=1 with x=0x%0h b=0x%0h, required none at cycle %0d",
                 bus.mac_x, bus.mac_b, cyc);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("mac_x_k%0d", e.k), 32'(bus.mac_x), 32'(e.x));
        chk($sformatf("mac_b_k%0d", e.k), 32'(bus.mac_b), 32'(e.b));
`ifdef FIR_SEQ_CLR_EN
        chk("mac_clr_term", 32'(bus.mac_clr), 32'(e.k == 0));
`endif
      end
    end else begin
      chk("idle_mac_x", 32'(bus.mac_x), 32'd0);
      chk("idle_mac_b", 32'(bus.mac_b), 32'd0);
`ifdef FIR_SEQ_CLR_EN
      chk("idle_mac_clr", 32'(bus.mac_clr), 32'd0);
`endif
    end
    if (bus.frame_done) begin
      if (done_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame_done: got pulse, required none at cycle %0d", cyc);
      end else begin
        chk("frame_done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frame_end();
    int n = 0;
    @(negedge clk);
    while ((!bus.in_ready || done_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready || done_q.size() != 0) chk("frame_end_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [DW-1:0] s, input bit cw, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd);
    @(negedge clk);
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.in_sample = s;
    bus.coef_we   = cw;
    bus.coef_addr = ca;
    bus.coef_data = cd;
    if (cw) coef_m[ca] = cd;
    model_accept(s);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
  endtask

  // Entered and left at a negedge.
  task automatic write_coef(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit exp_drop);
    bus.coef_we   = 1'b1;
    bus.coef_addr = a;
    bus.coef_data = d;
    if (!exp_drop) coef_m[a] = d;
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
    @(negedge clk);
    chk(exp_drop ? "coef_drop_busy" : "coef_drop_idle", 32'(bus.coef_drop), 32'(exp_drop));
  endtask

  task automatic load_coefs(input bit ramp);
    for (int k = 0; k < TAPS; k++) begin
      write_coef(AW'(k), ramp ? DW'(k + 1) : DW'(1), 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
    chk("rst_mac_en",     32'(bus.mac_en),     32'd0);
    chk("rst_mac_x",      32'(bus.mac_x),      32'd0);
    chk("rst_mac_b",      32'(bus.mac_b),      32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_coef_drop",  32'(bus.coef_drop),  32'd0);
    rst = 1'b0;
  endtask

  task automatic stream(input int n);
    int prev = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    for (int i = 1; i <= n; i++) begin
      bus.in_sample = DW'(i);
      wait_ready();
      model_accept(DW'(i));
      if (i > 1) chk("accept_spacing", 32'(cyc - prev), 32'(TAPS + 2));
      prev = cyc;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;

    do_reset();
    load_coefs(1'b0);
    send(16'd100, 1'b0, '0, '0);
    wait_frame_end();

    do_reset();
    load_coefs(1'b1);
    send(16'd1, 1'b0, '0, '0);
    wait_frame_end();
    send(16'd0, 1'b0, '0, '0);
    wait_frame_end();

    send(16'd7, 1'b0, '0, '0);
    repeat (5) @(negedge clk);
    write_coef(AW'(3), 16'h0055, 1'b1);
    wait_frame_end();
    send(16'd6, 1'b0, '0, '0);
    wait_frame_end();
    write_coef(AW'(3), 16'h0055, 1'b0);
    send(16'd8, 1'b0, '0, '0);
    wait_frame_end();

    send(16'd9, 1'b1, '0, 16'h0077);
    wait_frame_end();

    send(16'd3, 1'b0, '0, '0);
    repeat (6) @(negedge clk);
    do_reset();
    send(16'd5, 1'b0, '0, '0);
    wait_frame_end();

    do_reset();
    load_coefs(1'b0);
    stream(17);
    wait_frame_end();

    chk("terms_outstanding", 32'(exp_q.size()), 32'd0);
    chk("frames_outstanding", 32'(done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
